multi_button_pulser: RTL and testbench
======================================

// Module: multi_button_pulser
// PURPOSE
//   Multi-channel successor to the single pulser: per channel, synchronises a raw push
//   input, debounces it, and emits a one-clock pulse on each debounced press.
//   Optional auto-repeat emits further pulses while the button stays held.
//   Sits between the board buttons/switches and the control FSMs that consume pulses.
// PARAMETERS
//   CHANNELS        4   number of independent button channels (>=1)
//   DEBOUNCE_CYCLES 4   consecutive stable samples required to change debounced level (>=1)
//   REPEAT_DELAY    16  cycles from press pulse to first repeat pulse (>=2)
//   REPEAT_PERIOD   4   cycles between subsequent repeat pulses (>=2)
// PORTS
//   clk        input   1         system clock, all logic on posedge
//   rst        input   1         synchronous, active-high reset
//   pushed     input   CHANNELS  raw asynchronous button levels, 1 = pushed
//   repeat_en  input   1         1 = auto-repeat active on all channels
//   pulse      output  CHANNELS  one-clock pulse per press / repeat, registered
//   held       output  CHANNELS  debounced button level, registered
// BEHAVIOUR
//   - Reset: sync flops, held, pulse, debounce and repeat counters all 0.
//   - Channels fully independent; all logic below is per channel, widths $clog2(max+1).
//   - Sync: 2-flop synchroniser s1<=pushed, s2<=s1. Only s2 feeds the debouncer.
//   - Debounce: cnt increments each edge s2!=held; any edge with s2==held clears cnt.
//     Edge where s2!=held and cnt==DEBOUNCE_CYCLES-1: held<=s2, cnt<=0.
//   - Press pulse: on the edge held goes 0->1, pulse<=1 for exactly one cycle.
//     Latency: E0 = first edge sampling pushed=1 (stable thereafter); held and pulse
//     rise after edge E0+DEBOUNCE_CYCLES+1. Release (held 1->0) never pulses.
//   - Glitch shorter than DEBOUNCE_CYCLES samples at s2: no change, no pulse.
//   - Repeat counter rc: cleared on press edge; while held=1 and repeat_en=1 rc counts
//     each cycle. rc reaching REPEAT_DELAY -> pulse, then every REPEAT_PERIOD cycles
//     after that -> pulse (rc wraps to REPEAT_DELAY-REPEAT_PERIOD, no overflow).
//   - repeat_en=0 or held=0: rc held at 0, no repeat pulses. repeat_en re-raised
//     while held: full REPEAT_DELAY elapses before next repeat.
//   - Repeat pulses continue during release debounce until held actually falls.
//   - pulse never high two consecutive cycles (REPEAT_PERIOD>=2 guarantees).
//   - rst mid-operation: everything cleared the same edge; pulse low next cycle.
//     Button still pushed after rst drops is treated as a new press: one pulse after
//     DEBOUNCE_CYCLES+2 edges.
// TESTING
//   1. Defaults, pushed[0] 0->1 held 40 cycles, repeat_en=0 -> pulse[0] exactly once,
//      after edge E0+5; held[0]=1 same cycle; pulse[3:1] stay 0.
//   2. pushed[1] high 3 cycles then low (glitch) -> held[1]=0, no pulse ever.
//   3. repeat_en=1, pushed[2] held 40 cycles -> pulses at press P, P+16, P+20, P+24,...
//      (5 pulses up to P+32); stop once held[2] falls.
//   4. Press ch0 and ch3 on same edge -> both pulse on same cycle, one cycle each.
//   5. rst asserted mid-repeat with pushed held -> pulse/held 0 next cycle; after rst
//      drops, one fresh press pulse DEBOUNCE_CYCLES+2 edges later.
//   6. repeat_en dropped at P+18 and re-raised at P+22 -> no pulse at P+20; next
//      repeat at P+38.

Source files
------------

// File: rtl/multi_button_pulser.sv
// Per-channel button conditioner: 2-flop synchroniser, counter debouncer, one-cycle
// press pulse, and optional auto-repeat pulses while the debounced level stays high.
module multi_button_pulser #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] pushed,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] held
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RC_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RC_REWIND = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic          r_s1;
            logic          r_s2;
            logic          r_held;
            logic          r_pulse;
            logic [DW-1:0] r_cnt;
            logic [RW-1:0] r_rc;
            logic          w_settle;
            logic          w_rise;
            logic          w_count;
            logic          w_rep_hit;

            assign w_settle  = (r_s2 != r_held) && (r_cnt == DB_LAST);
            assign w_rise    = w_settle && r_s2;
            assign w_count   = r_held && repeat_en;
            // Rewinding the counter instead of resetting it keeps every later
            // repeat exactly REPEAT_PERIOD apart without a second counter.
            assign w_rep_hit = w_count && (r_rc == RC_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_held  <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                    r_rc    <= '0;
                end else begin
                    r_s1 <= pushed[gi];
                    r_s2 <= r_s1;

                    if (r_s2 == r_held) begin
                        r_cnt <= '0;
                    end else if (w_settle) begin
                        r_held <= r_s2;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end

                    r_pulse <= w_rise | w_rep_hit;

                    if (!w_count) begin
                        r_rc <= '0;
                    end else if (w_rep_hit) begin
                        r_rc <= RC_REWIND;
                    end else begin
                        r_rc <= r_rc + RW'(1);
                    end
                end
            end

            assign pulse[gi] = r_pulse;
            assign held[gi]  = r_held;
        end
    endgenerate

endmodule

// File: tb/tb_multi_button_pulser.sv
// Bench for multi_button_pulser: directed scenarios plus a random soak, all checked
// cycle by cycle against a run-length / elapsed-time model of the button behaviour.
module tb_multi_button_pulser;

    localparam int CH = 4;
    localparam int DC = 4;
    localparam int RD = 16;
    localparam int RP = 4;

    logic          clk;
    logic          rst;
    logic [CH-1:0] pushed;
    logic          repeat_en;
    logic [CH-1:0] pulse;
    logic [CH-1:0] held;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state: delayed input samples, debounced level, length of the current
    // disagreement run, and number of consecutive repeat-enabled held cycles.
    bit m_s1[CH];
    bit m_s2[CH];
    bit m_held[CH];
    bit m_pulse[CH];
    int m_run[CH];
    int m_age[CH];
    logic [CH-1:0] e_pulse;
    logic [CH-1:0] e_held;

    multi_button_pulser #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .pushed(pushed), .repeat_en(repeat_en),
        .pulse(pulse), .held(held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            bit old_held;
            bit new_held;
            bit rep;
            old_held = m_held[c];
            new_held = old_held;
            rep = 1'b0;
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_held[c] = 0; m_pulse[c] = 0;
                m_run[c] = 0; m_age[c] = 0;
            end else begin
                if (m_s2[c] != old_held) begin
                    m_run[c]++;
                    if (m_run[c] == DC) begin
                        new_held = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (old_held && repeat_en) begin
                    m_age[c]++;
                    rep = (m_age[c] >= RD) && (((m_age[c] - RD) % RP) == 0);
                end else begin
                    m_age[c] = 0;
                end
                m_pulse[c] = (!old_held && new_held) || rep;
                m_held[c]  = new_held;
                m_s2[c]    = m_s1[c];
                m_s1[c]    = pushed[c];
            end
        end
        #1;
        for (int c = 0; c < CH; c++) begin
            e_pulse[c] = m_pulse[c];
            e_held[c]  = m_held[c];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++;
        if (pulse !== 4'b0000 || held !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset pulse=%b held=%b expected 0000/0000", pulse, held);
        end
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL reset_idle t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
        end
    endtask

    task automatic test_single_press();
        int first;
        int cnt;
        int others;
        first = -1; cnt = 0; others = 0;
        repeat_en = 1'b0;
        pushed[0] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL single_press t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            if (pulse[0] === 1'b1) begin
                cnt++;
                if (first < 0) first = t;
            end
            if (pulse[3:1] !== 3'b000) others++;
            if (t == DC + 2) begin
                n_vec++;
                if (held[0] !== 1'b1) begin
                    n_miss++;
                    $display("FAIL single_press_held t=%0d held0=%b expected 1", t, held[0]);
                end
            end
        end
        n_vec++;
        if (first != DC + 2 || cnt != 1 || others != 0) begin
            n_miss++;
            $display("FAIL single_press_timing first=%0d count=%0d others=%0d expected %0d/1/0", first, cnt, others, DC + 2);
        end
        pushed[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL single_release t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
        end
    endtask

    task automatic test_glitch();
        int events;
        events = 0;
        pushed[1] = 1'b1;
        for (int t = 0; t < 18; t++) begin
            if (t == 3) pushed[1] = 1'b0;
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL glitch t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            if (pulse[1] !== 1'b0 || held[1] !== 1'b0) events++;
        end
        n_vec++;
        if (events != 0) begin
            n_miss++;
            $display("FAIL glitch_quiet events=%0d expected 0", events);
        end
    endtask

    task automatic test_repeat();
        int pt[$];
        int p0;
        int reps;
        bit fell;
        int late;
        reps = 0; fell = 0; late = 0;
        repeat_en = 1'b1;
        pushed[2] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL repeat t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            if (pulse[2] === 1'b1) pt.push_back(t);
        end
        p0 = (pt.size() > 0) ? pt[0] : -100;
        foreach (pt[i]) if (pt[i] > p0 && pt[i] <= p0 + 32) reps++;
        n_vec++;
        if (p0 != DC + 2 || reps != 5) begin
            n_miss++;
            $display("FAIL repeat_count press=%0d repeats=%0d expected %0d/5", p0, reps, DC + 2);
        end
        n_vec++;
        if (pt.size() < 3 || pt[1] - p0 != RD || pt[2] - pt[1] != RP) begin
            n_miss++;
            $display("FAIL repeat_spacing pulses=%0d expected first gap %0d then %0d", pt.size(), RD, RP);
        end
        pushed[2] = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL repeat_release t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            if (fell && pulse[2] === 1'b1) late++;
            if (held[2] === 1'b0) fell = 1;
        end
        n_vec++;
        if (!fell || late != 0) begin
            n_miss++;
            $display("FAIL repeat_stop fell=%0d late_pulses=%0d expected 1/0", fell, late);
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        int t0;
        int t3;
        int c0;
        int c3;
        t0 = -1; t3 = -2; c0 = 0; c3 = 0;
        pushed[0] = 1'b1;
        pushed[3] = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL simultaneous t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            if (pulse[0] === 1'b1) begin c0++; t0 = t; end
            if (pulse[3] === 1'b1) begin c3++; t3 = t; end
        end
        n_vec++;
        if (t0 != t3 || c0 != 1 || c3 != 1) begin
            n_miss++;
            $display("FAIL simultaneous_align t0=%0d t3=%0d c0=%0d c3=%0d expected equal times, 1 each", t0, t3, c0, c3);
        end
        pushed[0] = 1'b0;
        pushed[3] = 1'b0;
        for (int t = 0; t < 10; t++) tick();
    endtask

    task automatic test_rst_mid();
        int first;
        first = -1;
        repeat_en = 1'b1;
        pushed[1] = 1'b1;
        for (int t = 0; t < 26; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL rst_mid_pre t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if (pulse !== 4'b0000 || held !== 4'b0000) begin
            n_miss++;
            $display("FAIL rst_mid_clear pulse=%b held=%b expected 0000/0000", pulse, held);
        end
        rst = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL rst_mid_post t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            if (pulse[1] === 1'b1 && first < 0) first = t;
        end
        n_vec++;
        if (first != DC + 2) begin
            n_miss++;
            $display("FAIL rst_mid_repress first=%0d expected %0d", first, DC + 2);
        end
        pushed[1] = 1'b0;
        repeat_en = 1'b0;
        for (int t = 0; t < 12; t++) tick();
    endtask

    task automatic test_repeat_pause();
        int p;
        int early;
        bit at38;
        p = -1; early = 0; at38 = 0;
        repeat_en = 1'b1;
        pushed[3] = 1'b1;
        for (int t = 0; t < 20 && p < 0; t++) begin
            tick();
            if (pulse[3] === 1'b1) p = t;
        end
        n_vec++;
        if (p < 0) begin
            n_miss++;
            $display("FAIL pause_press no press pulse within 20 cycles, expected one");
        end
        for (int r = 1; r <= 40; r++) begin
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL pause r=%0d pulse=%b held=%b expected %b/%b", r, pulse, held, e_pulse, e_held);
            end
            if (r >= 17 && r <= 37 && pulse[3] === 1'b1) early++;
            if (r == 38) at38 = pulse[3];
            if (r == 18) repeat_en = 1'b0;
            if (r == 22) repeat_en = 1'b1;
        end
        n_vec++;
        if (early != 0 || !at38) begin
            n_miss++;
            $display("FAIL pause_timing pulses_r17_37=%0d pulse_r38=%0d expected 0/1", early, at38);
        end
        pushed[3] = 1'b0;
        repeat_en = 1'b0;
        for (int t = 0; t < 12; t++) tick();
    endtask

    task automatic test_random();
        logic [CH-1:0] prev;
        prev = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 99) < 7) pushed[c] = ~pushed[c];
            if ($urandom_range(0, 99) < 3) repeat_en = ~repeat_en;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            n_vec++;
            if (pulse !== e_pulse || held !== e_held) begin
                n_miss++;
                $display("FAIL random t=%0d pulse=%b held=%b expected %b/%b", t, pulse, held, e_pulse, e_held);
            end
            n_vec++;
            if ((pulse & prev) !== 4'b0000) begin
                n_miss++;
                $display("FAIL random_back_to_back t=%0d pulse=%b prev=%b expected no overlap", t, pulse, prev);
            end
            prev = pulse;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pushed = '0;
        repeat_en = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_repeat();
        test_simultaneous();
        test_rst_mid();
        test_repeat_pause();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
